// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC job dispatcher and its operand checker.
package ecc_pkg;

  localparam int ECC_OPW  = 4;
  localparam int ECC_SIZE = 32;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_INF     = 2'b01;
  localparam logic [1:0] STATUS_BAD     = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } disp_state_t;

endpackage

// File: rtl/ecc_operand_check.sv
// Combinational operand screen: flags unusable field parameters and the k==0 point-at-infinity case.
module ecc_operand_check #(
  parameter int OPW = ecc_pkg::ECC_OPW
) (
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] prime,
  input  logic [OPW-1:0] px,
  input  logic [OPW-1:0] py,
  input  logic [OPW-1:0] k,
  output logic           bad,
  output logic           inf
);

  // The field needs an odd modulus of at least 3, and every coordinate must already be reduced.
  assign bad = (prime < OPW'(3)) || !prime[0] || (a >= prime) || (px >= prime) || (py >= prime);
  assign inf = (k == '0);

endmodule

// File: rtl/ecc_job_dispatcher.sv
// Valid/ready front end for the scalar-multiplication engine: screens operands, launches, waits and returns a status.
module ecc_job_dispatcher
  import ecc_pkg::*;
#(
  parameter int SIZE    = ECC_SIZE,
  parameter int OPW     = ECC_OPW,
  parameter int TIMEOUT = 50000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [OPW-1:0]  i_a,
  input  logic [OPW-1:0]  i_prime,
  input  logic [OPW-1:0]  i_Px,
  input  logic [OPW-1:0]  i_Py,
  input  logic [OPW-1:0]  i_k,
  output logic            o_eng_start,
  output logic [OPW-1:0]  o_eng_a,
  output logic [OPW-1:0]  o_eng_prime,
  output logic [OPW-1:0]  o_eng_Px,
  output logic [OPW-1:0]  o_eng_Py,
  output logic [OPW-1:0]  o_eng_k,
  input  logic            i_eng_done,
  input  logic [SIZE-1:0] i_eng_kPx,
  input  logic [SIZE-1:0] i_eng_kPy,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [SIZE-1:0] o_rsp_kPx,
  output logic [SIZE-1:0] o_rsp_kPy,
  output logic [1:0]      o_rsp_status,
  output logic            o_busy
);

  localparam int              CNTW     = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  disp_state_t     state;
  logic [CNTW-1:0] wait_cnt;
  logic            op_bad;
  logic            op_inf;

  ecc_operand_check #(.OPW(OPW)) u_check (
    .a     (i_a),
    .prime (i_prime),
    .px    (i_Px),
    .py    (i_Py),
    .k     (i_k),
    .bad   (op_bad),
    .inf   (op_inf)
  );

  assign o_req_ready = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      o_eng_start  <= 1'b0;
      o_eng_a      <= '0;
      o_eng_prime  <= '0;
      o_eng_Px     <= '0;
      o_eng_Py     <= '0;
      o_eng_k      <= '0;
      o_rsp_valid  <= 1'b0;
      o_rsp_kPx    <= '0;
      o_rsp_kPy    <= '0;
      o_rsp_status <= STATUS_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            o_eng_a     <= i_a;
            o_eng_prime <= i_prime;
            o_eng_Px    <= i_Px;
            o_eng_Py    <= i_Py;
            o_eng_k     <= i_k;
            // Rejected jobs answer immediately and never touch the engine; BAD outranks INF.
            if (op_bad || op_inf) begin
              o_rsp_kPx    <= '0;
              o_rsp_kPy    <= '0;
              o_rsp_status <= op_bad ? STATUS_BAD : STATUS_INF;
              o_rsp_valid  <= 1'b1;
              state        <= ST_RESP;
            end else begin
              o_eng_start <= 1'b1;
              state       <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          o_eng_start <= 1'b0;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_eng_done) begin
            o_rsp_kPx    <= i_eng_kPx;
            o_rsp_kPy    <= i_eng_kPy;
            o_rsp_status <= STATUS_OK;
            o_rsp_valid  <= 1'b1;
            state        <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            o_rsp_kPx    <= '0;
            o_rsp_kPy    <= '0;
            o_rsp_status <= STATUS_TIMEOUT;
            o_rsp_valid  <= 1'b1;
            state        <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_job_dispatcher.sv
// Scoreboard bench for ecc_job_dispatcher: a cycle-stepped engine model answers each launch and responses are checked in order.
module tb_ecc_job_dispatcher;

  localparam int OPW     = 8;
  localparam int SIZE    = 32;
  localparam int TIMEOUT = 20;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_req_valid;
  logic            o_req_ready;
  logic [OPW-1:0]  i_a, i_prime, i_Px, i_Py, i_k;
  logic            o_eng_start;
  logic [OPW-1:0]  o_eng_a, o_eng_prime, o_eng_Px, o_eng_Py, o_eng_k;
  logic            i_eng_done;
  logic [SIZE-1:0] i_eng_kPx, i_eng_kPy;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [SIZE-1:0] o_rsp_kPx, o_rsp_kPy;
  logic [1:0]      o_rsp_status;
  logic            o_busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [SIZE-1:0] kpx;
    logic [SIZE-1:0] kpy;
    logic [1:0]      status;
  } rsp_t;

  rsp_t exp_q[$];

  always #5 i_clk = ~i_clk;

  ecc_job_dispatcher #(.SIZE(SIZE), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_a          (i_a),
    .i_prime      (i_prime),
    .i_Px         (i_Px),
    .i_Py         (i_Py),
    .i_k          (i_k),
    .o_eng_start  (o_eng_start),
    .o_eng_a      (o_eng_a),
    .o_eng_prime  (o_eng_prime),
    .o_eng_Px     (o_eng_Px),
    .o_eng_Py     (o_eng_Py),
    .o_eng_k      (o_eng_k),
    .i_eng_done   (i_eng_done),
    .i_eng_kPx    (i_eng_kPx),
    .i_eng_kPy    (i_eng_kPy),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_kPx    (o_rsp_kPx),
    .o_rsp_kPy    (o_rsp_kPy),
    .o_rsp_status (o_rsp_status),
    .o_busy       (o_busy)
  );

  function automatic logic [1:0] model_status(input logic [OPW-1:0] a, p, px, py, k);
    if (p < 3 || p[0] == 1'b0 || a >= p || px >= p || py >= p) return 2'b10;
    if (k == 0) return 2'b01;
    return 2'b00;
  endfunction

  // Drives one job from an IDLE negedge; cycle 0 is the acceptance cycle, done_delay counts cycles after the start pulse.
  task automatic run_job(input logic [OPW-1:0] a, p, px, py, k, input int done_delay,
                         input logic [SIZE-1:0] rx, ry, input int hold, input bit spurious);
    logic [1:0]       st;
    rsp_t             e, got, held;
    int               exp_rsp, exp_starts, starts, start_cyc, rsp_cyc;
    logic [5*OPW-1:0] ops;
    st = model_status(a, p, px, py, k);
    if (st != 2'b00) begin
      e = {{SIZE{1'b0}}, {SIZE{1'b0}}, st};
      exp_rsp = 1;
      exp_starts = 0;
    end else if (done_delay >= 1 && done_delay <= TIMEOUT) begin
      e = {rx, ry, 2'b00};
      exp_rsp = done_delay + 2;
      exp_starts = 1;
    end else begin
      e = {{SIZE{1'b0}}, {SIZE{1'b0}}, 2'b11};
      exp_rsp = TIMEOUT + 2;
      exp_starts = 1;
    end
    exp_q.push_back(e);
    ops = {a, p, px, py, k};
    {i_a, i_prime, i_Px, i_Py, i_k} = ops;
    i_req_valid = 1'b1;
    vectors++;
    if (o_req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL req_ready_idle: got %b want 1", o_req_ready);
    end
    starts = 0;
    start_cyc = -1;
    rsp_cyc = -1;
    for (int cyc = 1; cyc <= TIMEOUT + 10 && rsp_cyc < 0; cyc++) begin
      @(negedge i_clk);
      i_req_valid = 1'b0;
      {i_a, i_prime, i_Px, i_Py, i_k} = ~ops;
      i_eng_done = 1'b0;
      i_eng_kPx = 32'hBAD0_0000 ^ 32'(cyc);
      i_eng_kPy = ~i_eng_kPx;
      if (o_eng_start === 1'b1) begin
        starts++;
        start_cyc = cyc;
      end
      vectors++;
      if ({o_eng_a, o_eng_prime, o_eng_Px, o_eng_Py, o_eng_k} !== ops) begin
        miscompares++;
        $display("[TB] FAIL eng_operands cyc %0d: got %h want %h", cyc,
                 {o_eng_a, o_eng_prime, o_eng_Px, o_eng_Py, o_eng_k}, ops);
      end
      if (o_rsp_valid === 1'b1) rsp_cyc = cyc;
      else if (start_cyc >= 0 && done_delay >= 0 && cyc == start_cyc + done_delay) begin
        i_eng_done = 1'b1;
        i_eng_kPx = rx;
        i_eng_kPy = ry;
      end
    end
    vectors++;
    if (rsp_cyc != exp_rsp) begin
      miscompares++;
      $display("[TB] FAIL rsp_latency: got cycle %0d want %0d", rsp_cyc, exp_rsp);
    end
    vectors++;
    if (starts != exp_starts) begin
      miscompares++;
      $display("[TB] FAIL start_pulses: got %0d want %0d", starts, exp_starts);
    end
    held = {o_rsp_kPx, o_rsp_kPy, o_rsp_status};
    for (int h = 0; h < hold; h++) begin
      if (spurious && h == 1) begin
        i_eng_done = 1'b1;
        i_eng_kPx = 32'h1234_5678;
        i_eng_kPy = 32'h9ABC_DEF0;
      end
      @(negedge i_clk);
      i_eng_done = 1'b0;
      vectors++;
      if ({o_rsp_kPx, o_rsp_kPy, o_rsp_status} !== held || o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rsp_hold h=%0d: got %h v%b r%b want %h v1 r0", h,
                 {o_rsp_kPx, o_rsp_kPy, o_rsp_status}, o_rsp_valid, o_req_ready, held);
      end
      vectors++;
      if ({o_eng_a, o_eng_prime, o_eng_Px, o_eng_Py, o_eng_k} !== ops) begin
        miscompares++;
        $display("[TB] FAIL eng_operands_hold: got %h want %h",
                 {o_eng_a, o_eng_prime, o_eng_Px, o_eng_Py, o_eng_k}, ops);
      end
    end
    i_rsp_ready = 1'b1;
    vectors++;
    if (o_rsp_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rsp_valid: got %b want 1", o_rsp_valid);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
      got = {o_rsp_kPx, o_rsp_kPy, o_rsp_status};
      if (got !== e) begin
        miscompares++;
        $display("[TB] FAIL rsp_data: got kPx=%h kPy=%h st=%b want kPx=%h kPy=%h st=%b",
                 got.kpx, got.kpy, got.status, e.kpx, e.kpy, e.status);
      end
    end
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_handshake: got v%b r%b b%b want v0 r1 b0", o_rsp_valid, o_req_ready, o_busy);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    i_eng_done = 1'b0;
    {i_a, i_prime, i_Px, i_Py, i_k} = '0;
    i_eng_kPx = '0;
    i_eng_kPy = '0;
    repeat (2) @(negedge i_clk);
    vectors++;
    if ({o_eng_start, o_rsp_valid, o_busy, o_eng_a, o_eng_prime, o_eng_Px, o_eng_Py, o_eng_k,
         o_rsp_kPx, o_rsp_kPy, o_rsp_status} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got start%b v%b busy%b st%b want all zero",
               o_eng_start, o_rsp_valid, o_busy, o_rsp_status);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    vectors++;
    if (o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got r%b b%b want r1 b0", o_req_ready, o_busy);
    end
  endtask

  task automatic test_normal();
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd2, 10, 32'd6, 32'd3, 0, 1'b0);
  endtask

  task automatic test_inf();
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd0, 10, 32'd6, 32'd3, 0, 1'b0);
  endtask

  task automatic test_bad_operands();
    run_job(8'd2, 8'd16, 8'd5, 8'd1, 8'd2, 10, 32'd6, 32'd3, 0, 1'b0);
    run_job(8'd2, 8'd17, 8'd17, 8'd1, 8'd2, 10, 32'd6, 32'd3, 0, 1'b0);
    run_job(8'd17, 8'd17, 8'd5, 8'd1, 8'd2, 10, 32'd6, 32'd3, 0, 1'b0);
    run_job(8'd0, 8'd1, 8'd0, 8'd0, 8'd2, 10, 32'd6, 32'd3, 0, 1'b0);
    run_job(8'd2, 8'd16, 8'd5, 8'd1, 8'd0, 10, 32'd6, 32'd3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd2, -1, 32'd6, 32'd3, 0, 1'b0);
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd2, TIMEOUT, 32'hCAFE_0001, 32'hCAFE_0002, 0, 1'b0);
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd2, TIMEOUT + 1, 32'd6, 32'd3, 0, 1'b0);
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd2, 0, 32'd6, 32'd3, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_job(8'd3, 8'd13, 8'd4, 8'd7, 8'd5, 4, 32'h0000_00AA, 32'h0000_0055, 5, 1'b1);
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd0, 10, 32'd6, 32'd3, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_job(8'd1, 8'd11, 8'd2, 8'd9, 8'd7, 1, 32'h1111_2222, 32'h3333_4444, 0, 1'b0);
    run_job(8'd1, 8'd11, 8'd12, 8'd9, 8'd7, 1, 32'd6, 32'd3, 0, 1'b0);
    run_job(8'd4, 8'd7, 8'd6, 8'd0, 8'd3, 7, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen;
    i_a = 8'd2; i_prime = 8'd17; i_Px = 8'd5; i_Py = 8'd1; i_k = 8'd2;
    i_req_valid = 1'b1;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_in_wait: got %b want 1", o_busy);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    vectors++;
    if (o_busy !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_eng_k !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got b%b r%b v%b k%h want b0 r1 v0 k00",
               o_busy, o_req_ready, o_rsp_valid, o_eng_k);
    end
    seen = 0;
    for (int c = 0; c < TIMEOUT + 5; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_rsp: got %0d valid cycles want 0", seen);
    end
    run_job(8'd2, 8'd17, 8'd5, 8'd1, 8'd2, 10, 32'd6, 32'd3, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_inf();
    test_bad_operands();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
